uart_modem_ctrl: RTL and testbench
==================================

# uart_modem_ctrl

Modem-line controller for the UART: owns the Modem Control Register (MCR) and Modem Status Register (MSR), drives RTS/DTR pads, synchronises CTS/DSR/RI/DCD, latches delta/trailing-edge events, raises the modem-status interrupt and runs RTS/CTS auto-flow control gating the transmitter. It sits between the register-file decode, the RX FIFO, the TX serialiser and the modem pads watched by the modem monitor agent.

## Interface
- SYNC_STAGES, 2, synchroniser depth on pad inputs (≥2)
- LEVEL_W, 5, width of RX FIFO level
- RTS_HI_THRESH, 14, RX level at/above which auto-RTS deasserts
- RTS_LO_THRESH, 8, RX level at/below which auto-RTS reasserts; require LO < HI ≤ 2^LEVEL_W−1, else elaboration error

- wb_clk_i  in  1  single clock
- wb_rst_i  in  1  synchronous, active-high reset
- cts_pad_i, dsr_pad_i, ri_pad_i, dcd_pad_i  in  1 each  asynchronous modem inputs
- rts_pad_o, dtr_pad_o  out  1 each  modem outputs, registered
- mcr_wr  in  1  MCR write strobe
- mcr_wdata  in  6  [0]DTR [1]RTS [2]OUT1 [3]OUT2 [4]LOOP [5]AFE
- mcr_o  out  6  current MCR
- msr_rd  in  1  MSR read strobe (clears deltas)
- msr_o  out  8  [7]DCD [6]RI [5]DSR [4]CTS [3]DDCD [2]TERI [1]DDSR [0]DCTS
- rx_fifo_level  in  LEVEL_W  RX FIFO occupancy
- tx_idle_i  in  1  serialiser idle
- tx_char_done_i  in  1  one-cycle pulse at stop-bit end
- tx_en_o  out  1  transmitter may start a character
- modem_int_o  out  1  OR of msr_o[3:0]

## Operation
- Reset: MCR=0, sync chains=0, msr_o=0, rts_pad_o=0, dtr_pad_o=0, modem_int_o=0, tx_en_o=0, TX FSM=HOLD, RTS FSM=ON. Reset mid-character aborts nothing externally; all state returns to reset values at the next edge.
- Status sources: LOOP=0 → synchronised pads; LOOP=1 → CTS←RTS, DSR←DTR, RI←OUT1, DCD←OUT2 (MCR bits), pads rts_pad_o/dtr_pad_o forced 0.
- Deltas: DCTS/DDSR/DDCD set on any change of the corresponding status bit; TERI set on RI 1→0 only. Sticky until cleared. Switching LOOP that changes a status bit sets its delta.
- msr_o is read as-is in the msr_rd cycle; deltas clear at the following edge. Delta event in the same cycle as msr_rd: set wins.
- afe_active = AFE & MCR.RTS.
- RTS FSM: ON→OFF when afe_active & level ≥ HI; OFF→ON when level ≤ LO or !afe_active. rts_pad_o = !LOOP & MCR.RTS & (!afe_active | state==ON). dtr_pad_o = !LOOP & MCR.DTR.
- TX FSM: HOLD→RUN when !afe_active | cts_status; RUN→HOLD when afe_active & !cts_status & (tx_idle_i | tx_char_done_i). tx_en_o = (state==RUN). A character in progress always completes.

## Timing
- mcr_wr in cycle N → mcr_o, rts_pad_o, dtr_pad_o updated at N+1.
- Pad edge sampled at edge N → msr_o[7:4] at N+SYNC_STAGES; delta bit and modem_int_o at N+SYNC_STAGES+1.
- Loopback path: MCR write at N → status at N+1, delta at N+2.
- RX level crossing threshold at cycle N → rts_pad_o changes at N+1.
- CTS drop: tx_en_o falls the cycle after the first qualifying tx_idle_i/tx_char_done_i with deasserted cts_status; CTS rise: tx_en_o rises one cycle after cts_status rises.
- modem_int_o falls the cycle after msr_rd unless a new event coincides.

## Configuration
- UART_MODEM_AUTOFLOW_EN defined: AFE bit, RTS hysteresis FSM and CTS gating implemented as above.
- Undefined: MCR[5] reads 0 and ignores writes, afe_active=0, rts_pad_o = !LOOP & MCR.RTS, tx_en_o = 1 from the first cycle after reset; rx_fifo_level, tx_idle_i, tx_char_done_i unused.

## Test plan
- Reset, then write MCR=0x03 → next cycle rts_pad_o=1, dtr_pad_o=1, mcr_o=0x03, msr_o=0x00, tx_en_o=1.
- Toggle cts_pad_i 0→1 → msr_o[4]=1 after 2 cycles, DCTS and modem_int_o=1 after 3; msr_rd → msr_o reads 0x11, next cycle 0x10, int=0.
- RI pulse 1→0 with msr_rd coincident with TERI set cycle → TERI remains 1; second msr_rd clears it.
- MCR=0x1F (LOOP) → pads 0, status reflects MCR: msr_o[7:4]=0xF, deltas DCTS/DDSR/DDCD set, TERI 0.
- AUTOFLOW: MCR=0x23, level ramps 0→14 → rts_pad_o=0 cycle after 14; falls to 9 → stays 0; 8 → rts_pad_o=1.
- AUTOFLOW: CTS drops mid-character with tx_idle_i=0 → tx_en_o stays 1 until tx_char_done_i, falls next cycle; CTS rises → tx_en_o=1 one cycle after msr_o[4] rises.

Source files
------------

// File: rtl/uart_modem_ctrl.sv
// uart_modem_ctrl
// Modem-line controller for the UART. It owns the Modem Control Register
// (MCR) and Modem Status Register (MSR), drives the RTS/DTR pads,
// synchronises the CTS/DSR/RI/DCD pads, and latches delta and trailing-edge
// events into sticky MSR bits. It raises the modem-status interrupt and,
// optionally, runs RTS/CTS automatic flow control that gates the transmitter.
//
// Optional feature macro: UART_MODEM_AUTOFLOW_EN
//   defined   - MCR[5] (AFE), the RTS hysteresis FSM and CTS gating of
//               the transmitter are implemented
//   undefined - MCR[5] reads 0, rts_pad_o follows MCR.RTS, and tx_en_o is 1
//               from the first cycle after reset
//
// Ports
//   wb_clk_i, wb_rst_i     clock, synchronous active-high reset
//   cts/dsr/ri/dcd_pad_i   asynchronous modem inputs
//   rts_pad_o, dtr_pad_o   modem outputs
//   mcr_wr, mcr_wdata      MCR write strobe and data
//                          [0]DTR [1]RTS [2]OUT1 [3]OUT2 [4]LOOP [5]AFE
//   mcr_o                  current MCR
//   msr_rd                 MSR read strobe; clears the delta bits
//   msr_o                  [7]DCD [6]RI [5]DSR [4]CTS [3]DDCD [2]TERI [1]DDSR [0]DCTS
//   rx_fifo_level          RX FIFO occupancy (auto-RTS hysteresis)
//   tx_idle_i              serialiser idle
//   tx_char_done_i         one-cycle pulse at the end of the stop bit
//   tx_en_o                transmitter may start a character
//   modem_int_o            OR of the MSR delta bits
module uart_modem_ctrl #(
  parameter int SYNC_STAGES   = 2,
  parameter int LEVEL_W       = 5,
  parameter int RTS_HI_THRESH = 14,
  parameter int RTS_LO_THRESH = 8
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cts_pad_i,
  input  logic               dsr_pad_i,
  input  logic               ri_pad_i,
  input  logic               dcd_pad_i,
  output logic               rts_pad_o,
  output logic               dtr_pad_o,
  input  logic               mcr_wr,
  input  logic [5:0]         mcr_wdata,
  output logic [5:0]         mcr_o,
  input  logic               msr_rd,
  output logic [7:0]         msr_o,
  input  logic [LEVEL_W-1:0] rx_fifo_level,
  input  logic               tx_idle_i,
  input  logic               tx_char_done_i,
  output logic               tx_en_o,
  output logic               modem_int_o
);

  // Parameter sanity checks, resolved at elaboration.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_modem_ctrl: SYNC_STAGES must be at least 2");
  end
  if (!((RTS_LO_THRESH < RTS_HI_THRESH) &&
        (RTS_HI_THRESH <= (2 ** LEVEL_W) - 1))) begin : g_bad_thresh
    $error("uart_modem_ctrl: need RTS_LO_THRESH < RTS_HI_THRESH <= 2**LEVEL_W-1");
  end

  logic [5:0] mcr_q;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] status;
  logic [3:0] status_prev;
  logic [3:0] delta_q;
  logic [3:0] delta_set;
  logic       loop;
  logic       afe_active;
  logic       cts_status;

  // Modem control register. Without auto-flow the AFE bit is tied to 0.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mcr_q <= '0;
    end else if (mcr_wr) begin
`ifdef UART_MODEM_AUTOFLOW_EN
      mcr_q <= mcr_wdata;
`else
      mcr_q <= {1'b0, mcr_wdata[4:0]};
`endif
    end
  end

  assign mcr_o = mcr_q;
  assign loop  = mcr_q[4];

  // Pad synchronisers; bit order matches msr_o[7:4] (DCD, RI, DSR, CTS).
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= {dcd_pad_i, ri_pad_i, dsr_pad_i, cts_pad_i};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // In loopback the status reflects MCR: DCD<-OUT2, RI<-OUT1, DSR<-DTR, CTS<-RTS.
  assign status     = loop ? {mcr_q[3], mcr_q[2], mcr_q[0], mcr_q[1]}
                           : sync_q[SYNC_STAGES-1];
  assign cts_status = status[0];

  // Deltas compare the status with its value one cycle earlier, so a
  // status change shows up as a delta one cycle after the status itself.
  // TERI only fires on the trailing (1->0) edge of RI.
  assign delta_set = {status_prev[3] ^ status[3],
                      status_prev[2] & ~status[2],
                      status_prev[1] ^ status[1],
                      status_prev[0] ^ status[0]};

  // A read clears the deltas at the following edge; a new event in the
  // same cycle still gets latched because it is ORed in after the clear.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      status_prev <= '0;
      delta_q     <= '0;
    end else begin
      status_prev <= status;
      delta_q     <= (msr_rd ? 4'b0000 : delta_q) | delta_set;
    end
  end

  assign msr_o       = {status, delta_q};
  assign modem_int_o = |delta_q;
  assign dtr_pad_o   = ~loop & mcr_q[0];

`ifdef UART_MODEM_AUTOFLOW_EN

  typedef enum logic {RTS_ON, RTS_OFF} rts_state_t;
  typedef enum logic {TX_HOLD, TX_RUN} tx_state_t;

  rts_state_t rts_state, rts_next;
  tx_state_t  tx_state,  tx_next;

  assign afe_active = mcr_q[5] & mcr_q[1];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rts_state <= RTS_ON;
      tx_state  <= TX_HOLD;
    end else begin
      rts_state <= rts_next;
      tx_state  <= tx_next;
    end
  end

  // RTS hysteresis: drop RTS when the RX FIFO fills to the high mark,
  // raise it again only once it drains to the low mark.
  always_comb begin
    rts_next = rts_state;
    case (rts_state)
      RTS_ON: begin
        if (afe_active && (rx_fifo_level >= LEVEL_W'(RTS_HI_THRESH))) begin
          rts_next = RTS_OFF;
        end
      end
      RTS_OFF: begin
        if (!afe_active || (rx_fifo_level <= LEVEL_W'(RTS_LO_THRESH))) begin
          rts_next = RTS_ON;
        end
      end
      default: rts_next = RTS_ON;
    endcase
  end

  // CTS gating: only stop the transmitter at a character boundary so a
  // character already on the line always completes.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_HOLD: begin
        if (!afe_active || cts_status) begin
          tx_next = TX_RUN;
        end
      end
      TX_RUN: begin
        if (afe_active && !cts_status && (tx_idle_i || tx_char_done_i)) begin
          tx_next = TX_HOLD;
        end
      end
      default: tx_next = TX_HOLD;
    endcase
  end

  assign rts_pad_o = ~loop & mcr_q[1] & (~afe_active | (rts_state == RTS_ON));
  assign tx_en_o   = (tx_state == TX_RUN);

`else

  logic tx_en_q;
  logic unused_inputs;

  assign afe_active = 1'b0;

  // Without flow control the transmitter is always allowed once out of reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      tx_en_q <= 1'b0;
    end else begin
      tx_en_q <= 1'b1;
    end
  end

  assign rts_pad_o     = ~loop & mcr_q[1] & ~afe_active;
  assign tx_en_o       = tx_en_q;
  assign unused_inputs = ^{rx_fifo_level, tx_idle_i, tx_char_done_i,
                           mcr_wdata[5], cts_status};

`endif

endmodule

// File: tb/tb_uart_modem_ctrl.sv
// tb_uart_modem_ctrl
// Directed bench for uart_modem_ctrl. Stimulus code schedules expected
// output values into a scoreboard queue, each tagged with the clock cycle
// at which it must hold; an independent monitor samples on the falling
// edge and compares every entry that falls due.
module tb_uart_modem_ctrl;

  localparam int SEL_MCR  = 0;
  localparam int SEL_MSR  = 1;
  localparam int SEL_RTS  = 2;
  localparam int SEL_DTR  = 3;
  localparam int SEL_TXEN = 4;
  localparam int SEL_INT  = 5;
  localparam int SEL_CTS  = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cts_pad = 1'b0, dsr_pad = 1'b0, ri_pad = 1'b0, dcd_pad = 1'b0;
  logic       rts_pad, dtr_pad;
  logic       mcr_wr = 1'b0;
  logic [5:0] mcr_wdata = '0;
  logic [5:0] mcr_o;
  logic       msr_rd = 1'b0;
  logic [7:0] msr_o;
  logic [4:0] level = '0;
  logic       tx_idle = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_en;
  logic       modem_int;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    int         due;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  logic [7:0] act;

  uart_modem_ctrl #(
    .SYNC_STAGES(2), .LEVEL_W(5), .RTS_HI_THRESH(14), .RTS_LO_THRESH(8)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cts_pad_i(cts_pad), .dsr_pad_i(dsr_pad), .ri_pad_i(ri_pad), .dcd_pad_i(dcd_pad),
    .rts_pad_o(rts_pad), .dtr_pad_o(dtr_pad),
    .mcr_wr(mcr_wr), .mcr_wdata(mcr_wdata), .mcr_o(mcr_o),
    .msr_rd(msr_rd), .msr_o(msr_o),
    .rx_fifo_level(level), .tx_idle_i(tx_idle), .tx_char_done_i(tx_done),
    .tx_en_o(tx_en), .modem_int_o(modem_int)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] actual(input int sel);
    case (sel)
      SEL_MCR:  return {2'b00, mcr_o};
      SEL_MSR:  return msr_o;
      SEL_RTS:  return {7'd0, rts_pad};
      SEL_DTR:  return {7'd0, dtr_pad};
      SEL_TXEN: return {7'd0, tx_en};
      SEL_INT:  return {7'd0, modem_int};
      SEL_CTS:  return {7'd0, msr_o[4]};
      default:  return 8'hxx;
    endcase
  endfunction

  // Schedule an expected value 'delay' cycles after the current cycle.
  task automatic checkOutput(input string name, input int sel,
                             input logic [7:0] exp, input int delay);
    exp_t e;
    e.name = name;
    e.due  = cyc + delay;
    e.sel  = sel;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle register strobes: MCR write and/or MSR read.
  task automatic applyStimulus(input logic wr, input logic [5:0] wdata,
                               input logic rd);
    mcr_wr    = wr;
    mcr_wdata = wdata;
    msr_rd    = rd;
    tick(1);
    mcr_wr = 1'b0;
    msr_rd = 1'b0;
  endtask

  // Monitor: compare every scoreboard entry that is due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        checks++;
        act = actual(sb[i].sel);
        if (act !== sb[i].exp) begin
          errors++;
          $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                   sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    tick(3);
    checkOutput("rst_mcr",  SEL_MCR,  8'h00, 0);
    checkOutput("rst_msr",  SEL_MSR,  8'h00, 0);
    checkOutput("rst_rts",  SEL_RTS,  8'h00, 0);
    checkOutput("rst_dtr",  SEL_DTR,  8'h00, 0);
    checkOutput("rst_txen", SEL_TXEN, 8'h00, 0);
    checkOutput("rst_int",  SEL_INT,  8'h00, 0);
    rst = 1'b0;
    tick(1);
    checkOutput("txen_after_rst", SEL_TXEN, 8'h01, 0);

    // MCR = DTR | RTS
    checkOutput("w03_mcr",  SEL_MCR,  8'h03, 1);
    checkOutput("w03_rts",  SEL_RTS,  8'h01, 1);
    checkOutput("w03_dtr",  SEL_DTR,  8'h01, 1);
    checkOutput("w03_msr",  SEL_MSR,  8'h00, 1);
    checkOutput("w03_txen", SEL_TXEN, 8'h01, 1);
    applyStimulus(1'b1, 6'h03, 1'b0);

    // CTS rise through the synchroniser, then read-to-clear
    cts_pad = 1'b1;
    checkOutput("cts_sync1", SEL_MSR, 8'h00, 1);
    checkOutput("cts_sync2", SEL_MSR, 8'h10, 2);
    checkOutput("cts_int2",  SEL_INT, 8'h00, 2);
    checkOutput("cts_dcts",  SEL_MSR, 8'h11, 3);
    checkOutput("cts_int3",  SEL_INT, 8'h01, 3);
    tick(3);
    checkOutput("cts_clr",     SEL_MSR, 8'h10, 1);
    checkOutput("cts_int_clr", SEL_INT, 8'h00, 1);
    applyStimulus(1'b0, 6'h03, 1'b1);

    // RI pulse; read coincides with the TERI set edge, set must win
    ri_pad = 1'b1;
    checkOutput("ri_high",  SEL_MSR, 8'h50, 2);
    checkOutput("ri_noint", SEL_INT, 8'h00, 3);
    tick(3);
    ri_pad = 1'b0;
    checkOutput("ri_still", SEL_MSR, 8'h50, 1);
    checkOutput("ri_low",   SEL_MSR, 8'h10, 2);
    tick(2);
    checkOutput("teri_set_wins", SEL_MSR, 8'h14, 1);
    checkOutput("teri_int",      SEL_INT, 8'h01, 1);
    applyStimulus(1'b0, 6'h03, 1'b1);
    checkOutput("teri_clr",     SEL_MSR, 8'h10, 1);
    checkOutput("teri_int_clr", SEL_INT, 8'h00, 1);
    applyStimulus(1'b0, 6'h03, 1'b1);

    // Drop CTS and clear its delta
    cts_pad = 1'b0;
    tick(3);
    checkOutput("cts_fall", SEL_MSR, 8'h01, 0);
    checkOutput("cts_fall_clr", SEL_MSR, 8'h00, 1);
    applyStimulus(1'b0, 6'h03, 1'b1);

    // Loopback
    checkOutput("loop_mcr",   SEL_MCR, 8'h1f, 1);
    checkOutput("loop_rts",   SEL_RTS, 8'h00, 1);
    checkOutput("loop_dtr",   SEL_DTR, 8'h00, 1);
    checkOutput("loop_stat",  SEL_MSR, 8'hf0, 1);
    checkOutput("loop_delta", SEL_MSR, 8'hfb, 2);
    checkOutput("loop_int",   SEL_INT, 8'h01, 2);
    applyStimulus(1'b1, 6'h1f, 1'b0);
    tick(1);
    checkOutput("unloop_mcr",   SEL_MCR, 8'h03, 1);
    checkOutput("unloop_rts",   SEL_RTS, 8'h01, 1);
    checkOutput("unloop_dtr",   SEL_DTR, 8'h01, 1);
    checkOutput("unloop_stat",  SEL_MSR, 8'h0b, 1);
    checkOutput("unloop_delta", SEL_MSR, 8'h0f, 2);
    applyStimulus(1'b1, 6'h03, 1'b0);
    tick(1);
    checkOutput("unloop_clr",     SEL_MSR, 8'h00, 1);
    checkOutput("unloop_int_clr", SEL_INT, 8'h00, 1);
    applyStimulus(1'b0, 6'h03, 1'b1);

`ifdef UART_MODEM_AUTOFLOW_EN
    checkOutput("afe_mcr",  SEL_MCR,  8'h23, 1);
    checkOutput("afe_rts",  SEL_RTS,  8'h01, 1);
    checkOutput("afe_txen", SEL_TXEN, 8'h01, 1);
    applyStimulus(1'b1, 6'h23, 1'b0);
    for (int l = 0; l <= 14; l++) begin
      level = 5'(l);
      checkOutput($sformatf("rts_lvl%0d", l), SEL_RTS,
                  (l < 14) ? 8'h01 : 8'h00, 1);
      tick(1);
    end
    level = 5'd9;
    checkOutput("rts_lvl9_down", SEL_RTS, 8'h00, 1);
    tick(1);
    level = 5'd8;
    checkOutput("rts_lvl8_down", SEL_RTS, 8'h01, 1);
    tick(1);

    // CTS drops mid-character: held until the character completes
    cts_pad = 1'b1;
    tick(3);
    checkOutput("afe_cts_up", SEL_CTS, 8'h01, 0);
    cts_pad = 1'b0;
    checkOutput("txen_midchar", SEL_TXEN, 8'h01, 5);
    tick(5);
    tx_done = 1'b1;
    checkOutput("txen_at_done",    SEL_TXEN, 8'h01, 0);
    checkOutput("txen_after_done", SEL_TXEN, 8'h00, 1);
    tick(1);
    tx_done = 1'b0;
    checkOutput("txen_held", SEL_TXEN, 8'h00, 2);
    tick(2);
    cts_pad = 1'b1;
    checkOutput("cts_rise_pre", SEL_CTS,  8'h00, 1);
    checkOutput("cts_rise",     SEL_CTS,  8'h01, 2);
    checkOutput("txen_pre",     SEL_TXEN, 8'h00, 2);
    checkOutput("txen_resume",  SEL_TXEN, 8'h01, 3);
    tick(4);
    // CTS drop while idle stops the transmitter right away
    cts_pad = 1'b0;
    tx_idle = 1'b1;
    checkOutput("idle_txen_pre",  SEL_TXEN, 8'h01, 2);
    checkOutput("idle_txen_stop", SEL_TXEN, 8'h00, 3);
    tick(4);
    tx_idle = 1'b0;
    // AFE without RTS disables flow control
    checkOutput("afe_nortsmcr", SEL_MCR,  8'h21, 1);
    checkOutput("afe_norts_rts", SEL_RTS, 8'h00, 1);
    checkOutput("afe_norts_hold", SEL_TXEN, 8'h00, 1);
    checkOutput("afe_norts_run", SEL_TXEN, 8'h01, 2);
    applyStimulus(1'b1, 6'h21, 1'b0);
    tick(2);
`else
    checkOutput("noafe_mcr", SEL_MCR, 8'h03, 1);
    applyStimulus(1'b1, 6'h23, 1'b0);
    level   = 5'd14;
    tx_idle = 1'b1;
    checkOutput("noafe_rts",  SEL_RTS,  8'h01, 2);
    checkOutput("noafe_txen", SEL_TXEN, 8'h01, 2);
    checkOutput("noafe_msr",  SEL_MSR,  8'h00, 2);
    tick(3);
`endif

    for (int n = 0; n < 20 && sb.size() > 0; n++) begin
      tick(1);
    end
    if (sb.size() > 0) begin
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      checks += sb.size();
      errors += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
